icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines (power of two, 2..256).
REQ-002 Parameter FILL_LAT, default 2, instruction-memory wait cycles before a fetched line is captured (0..15).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 req_i  input  1  CPU fetch request for pc_i this cycle.
REQ-006 pc_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 flush_i  input  1  invalidate every line (fence.i).
REQ-008 instr_o  output  32  fetched instruction word.
REQ-009 valid_o  output  1  instr_o valid for pc_i this cycle.
REQ-010 stall_o  output  1  CPU must hold pc_i and req_i.
REQ-011 mem_addr_o  output  32  line-aligned address to instruction memory, {line_addr[31:5], 5'b0}.
REQ-012 mem_req_o  output  1  high while a line fill is outstanding.
REQ-013 mem_line_i  input  256  eight-word line from instruction memory, word k in bits [32k+31:32k].

Function
REQ-014 Address split: word = pc[4:2], index = pc[5+IDX_W-1:5], tag = pc[31:5+IDX_W], IDX_W = log2(NUM_LINES).
REQ-015 States: LOOKUP, FILL_WAIT, FILL_WRITE.
REQ-016 LOOKUP, req_i=0: valid_o=0, stall_o=0, no state change.
REQ-017 LOOKUP, req_i=1, valid[index] and tag match: same-cycle valid_o=1, stall_o=0, instr_o = data[index][word].
REQ-018 LOOKUP, req_i=1, miss: same-cycle stall_o=1, valid_o=0; latch pc[31:5] into fill address; load wait counter with FILL_LAT; next state FILL_WAIT.
REQ-019 FILL_WAIT: mem_req_o=1, stall_o=1, mem_addr_o from latched address (not pc_i); counter decrements each cycle; exit to FILL_WRITE the cycle after counter==0 (FILL_LAT+1 cycles total).
REQ-020 FILL_WRITE: write mem_line_i into data[latched index], set tag and valid, mem_req_o=1, stall_o=1; next state LOOKUP.
REQ-021 Miss penalty: miss in cycle N yields hit (valid_o=1) in cycle N+FILL_LAT+3.
REQ-022 flush_i in LOOKUP: all valid bits clear at next edge; stall_o=1 that cycle; flush has priority over hit/miss handling.
REQ-023 flush_i in FILL_WAIT/FILL_WRITE: recorded in a pending flag; fill completes; invalidation applied on the first LOOKUP cycle with stall_o=1.
REQ-024 mem_addr_o and mem_req_o are 0 in LOOKUP; instr_o is 0 whenever valid_o=0.

Reset
REQ-025 RST_N=0 at an edge: state LOOKUP, all valid bits 0, wait counter 0, pending flush 0, all outputs 0; aborts any fill in progress with no array write.
REQ-026 Data and tag arrays need not be reset.

Configuration
REQ-027 Macro ICACHE_PERF_EN defined: outputs hit_cnt_o and miss_cnt_o (32 bits each) count LOOKUP hits and misses, wrap at 2^32, clear on reset, unaffected by flush.
REQ-028 ICACHE_PERF_EN undefined: these ports and counters do not exist; all other behaviour identical.

Structure
REQ-029 Package icache_pkg holds the state enum, LINE_WORDS=8, LINE_BITS=256, and OFFSET_W=5.
REQ-030 Sub-module icache_line_ram holds data, tag and valid arrays: async read, sync write, bulk-invalidate port.

Verification
REQ-031 Cold miss: reset, req_i=1, pc_i=0x0000_0040, FILL_LAT=2 -> stall_o 1 for cycles 0-4, mem_addr_o=0x40, then valid_o=1 with word 0 of line.
REQ-032 Same-line hits: after REQ-031, pc_i=0x44..0x5C -> valid_o=1 every cycle, no mem_req_o.
REQ-033 Conflict: pc_i=0x0000_0040 then 0x0000_0240 (NUM_LINES=16, same index) -> second access misses, refills, and first access then misses again.
REQ-034 Flush mid-fill: flush_i pulsed during FILL_WAIT -> line written, invalidated on return to LOOKUP, re-access of same pc misses.
REQ-035 Reset mid-fill: RST_N=0 during FILL_WAIT -> next cycle state LOOKUP, mem_req_o=0, re-access of same pc misses.
REQ-036 With ICACHE_PERF_EN: sequence REQ-031 plus REQ-032 -> miss_cnt_o=1, hit_cnt_o=8.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and line geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_W    = 5;
  localparam int ADDR_W      = 32;
  localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    LOOKUP     = 2'd0,
    FILL_WAIT  = 2'd1,
    FILL_WRITE = 2'd2
  } state_e;

  // Word k of a line lives in bits [32k+31:32k].
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [2:0]           word);
    return line[{word, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Line storage: data, tag and valid arrays with async read, sync write and
// a single-cycle invalidate-all.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = LINE_ADDR_W - IDX_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 inval_all
);

  logic [LINE_BITS-1:0] data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // NOTE: data and tag arrays carry no reset; a line is only trusted once its
  // valid bit is set, so clearing the valid vector is enough.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_line;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q <= '0;
    end else if (inval_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with blocking line fills.
// Optional ICACHE_PERF_EN adds hit/miss performance counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int FILL_LAT  = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_i,
  input  logic [31:0]          pc_i,
  input  logic                 flush_i,
  output logic [31:0]          instr_o,
  output logic                 valid_o,
  output logic                 stall_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_req_o,
  input  logic [LINE_BITS-1:0] mem_line_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [LINE_ADDR_W-1:0] fill_la_q;
  logic                   flush_pend_q;
  logic                   mem_req_q;
  logic [31:0]            mem_addr_q;

  logic [IDX_W-1:0]     pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [2:0]           pc_word;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 tag_hit;
  logic                 in_lookup;
  logic                 flush_now;
  logic                 lookup_hit;
  logic                 lookup_miss;
  logic                 unused_pc_bits;

  assign pc_idx         = pc_i[OFFSET_W +: IDX_W];
  assign pc_tag         = pc_i[ADDR_W-1 -: TAG_W];
  assign pc_word        = pc_i[4:2];
  assign unused_pc_bits = ^pc_i[1:0];

  icache_line_ram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_line_ram (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rd_idx    (pc_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     ((state_q == FILL_WRITE) && RST_N),
    .wr_idx    (fill_la_q[IDX_W-1:0]),
    .wr_tag    (fill_la_q[LINE_ADDR_W-1 -: TAG_W]),
    .wr_line   (mem_line_i),
    .inval_all (flush_now && RST_N)
  );

  // A pending fence.i is serviced before any lookup, so it blocks hits too.
  assign tag_hit     = rd_valid && (rd_tag == pc_tag);
  assign in_lookup   = (state_q == LOOKUP);
  assign flush_now   = in_lookup && (flush_i || flush_pend_q);
  assign lookup_hit  = in_lookup && !flush_now && req_i && tag_hit;
  assign lookup_miss = in_lookup && !flush_now && req_i && !tag_hit;

  assign valid_o    = lookup_hit;
  assign instr_o    = lookup_hit ? line_word(rd_line, pc_word) : 32'h0;
  assign stall_o    = !in_lookup || flush_now || lookup_miss;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  // NOTE: every register here is updated with <= so all next-state terms see
  // the values from before this edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= LOOKUP;
      cnt_q        <= '0;
      fill_la_q    <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (flush_now) begin
            flush_pend_q <= 1'b0;
          end else if (lookup_miss) begin
            fill_la_q  <= pc_i[ADDR_W-1:OFFSET_W];
            cnt_q      <= 4'(FILL_LAT);
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_i[ADDR_W-1:OFFSET_W], 5'b00000};
            state_q    <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q <= FILL_WRITE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        FILL_WRITE: begin
          if (flush_i) flush_pend_q <= 1'b1;
          mem_req_q  <= 1'b0;
          mem_addr_q <= '0;
          state_q    <= LOOKUP;
        end
        default: begin
          state_q <= LOOKUP;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl against a cycle-level behavioural model.
module tb_icache_ctrl;

  localparam int NUM_LINES = 16;
  localparam int FILL_LAT  = 2;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         req_i;
  logic [31:0]  pc_i;
  logic         flush_i;
  logic [31:0]  instr_o;
  logic         valid_o;
  logic         stall_o;
  logic [31:0]  mem_addr_o;
  logic         mem_req_o;
  logic [255:0] mem_line_i;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  always #5 CLK = ~CLK;

  icache_ctrl #(
    .NUM_LINES (NUM_LINES),
    .FILL_LAT  (FILL_LAT)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_i      (req_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .valid_o    (valid_o),
    .stall_o    (stall_o),
    .mem_addr_o (mem_addr_o),
    .mem_req_o  (mem_req_o),
    .mem_line_i (mem_line_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which line address each index holds, plus how many
  // stalled cycles remain in the current fill.
  int          busy = 0;
  logic [26:0] fill_la = '0;
  bit          pend = 1'b0;
  bit          mvalid [NUM_LINES];
  logic [26:0] mline  [NUM_LINES];
  int unsigned hits = 0;
  int unsigned misses = 0;
  bit          last_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [26:0] la, input int k);
    return (32'(la) * 32'h9E37_79B1) ^ (32'(k) * 32'h0101_0101) ^ 32'h1234_5678;
  endfunction

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(la, k);
    return l;
  endfunction

  task automatic cycle(input bit rst, input bit req, input logic [31:0] pc, input bit flush);
    logic        e_stall, e_valid, e_req;
    logic [31:0] e_instr, e_addr;
    logic [26:0] la;
    int          idx;
    @(negedge CLK);
    RST_N      = !rst;
    req_i      = req;
    pc_i       = pc;
    flush_i    = flush;
    mem_line_i = (busy > 0) ? mem_line(fill_la)
                            : {8{$urandom()}};
    #1;
    e_stall = 1'b0; e_valid = 1'b0; e_req = 1'b0; e_instr = '0; e_addr = '0;
    if (rst) begin
      busy = 0; pend = 1'b0; hits = 0; misses = 0;
      for (int i = 0; i < NUM_LINES; i++) mvalid[i] = 1'b0;
      last_stall = 1'b0;
      return;
    end
`ifdef ICACHE_PERF_EN
    check("hit_cnt", hit_cnt_o, hits);
    check("miss_cnt", miss_cnt_o, misses);
`endif
    la  = pc[31:5];
    idx = int'(la) % NUM_LINES;
    if (busy == 0) begin
      if (flush || pend) begin
        e_stall = 1'b1;
        pend = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) mvalid[i] = 1'b0;
      end else if (req) begin
        if (mvalid[idx] && mline[idx] == la) begin
          e_valid = 1'b1;
          e_instr = mem_word(la, int'(pc[4:2]));
          hits++;
        end else begin
          e_stall = 1'b1;
          misses++;
          busy    = FILL_LAT + 2;
          fill_la = la;
        end
      end
    end else begin
      e_stall = 1'b1;
      e_req   = 1'b1;
      e_addr  = {fill_la, 5'b00000};
      if (flush) pend = 1'b1;
      busy--;
      if (busy == 0) begin
        mvalid[int'(fill_la) % NUM_LINES] = 1'b1;
        mline[int'(fill_la) % NUM_LINES]  = fill_la;
      end
    end
    check("stall_o", 32'(stall_o), 32'(e_stall));
    check("valid_o", 32'(valid_o), 32'(e_valid));
    check("instr_o", instr_o, e_instr);
    check("mem_req_o", 32'(mem_req_o), 32'(e_req));
    check("mem_addr_o", mem_addr_o, e_addr);
    last_stall = e_stall;
  endtask

  // Present pc until the model sees it delivered, with a cycle budget.
  task automatic access(input logic [31:0] pc);
    int n = 0;
    cycle(1'b0, 1'b1, pc, 1'b0);
    while (last_stall) begin
      if (n++ > 40) begin
        n_checks++;
        n_errors++;
        $display("FAIL access_timeout: pc %h still stalled after %0d cycles", pc, n);
        return;
      end
      cycle(1'b0, 1'b1, pc, 1'b0);
    end
  endtask

  initial begin
    bit          cur_req;
    logic [31:0] cur_pc;
    bit          rst, flush;

    RST_N = 1'b0; req_i = 1'b0; pc_i = '0; flush_i = 1'b0; mem_line_i = '0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Cold miss, then the rest of the same line hits.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    for (int a = 'h44; a <= 'h5C; a += 4) cycle(1'b0, 1'b1, 32'(a), 1'b0);

    // Conflict on the same index.
    access(32'h0000_0240);
    access(32'h0000_0040);

    // Flush during FILL_WAIT: line lands, then is invalidated, then misses again.
    cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    access(32'h0000_0084);

    // Reset during FILL_WAIT aborts the fill.
    cycle(1'b0, 1'b1, 32'h0000_00C0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_00C0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_00C0, 1'b0);
    access(32'h0000_00C0);

    // Random traffic over 48 lines so conflicts and flushes interleave.
    cur_req = 1'b0;
    cur_pc  = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        cur_req = ($urandom_range(0, 3) != 0);
        cur_pc  = {21'(0), 6'($urandom_range(0, 47)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3))};
      end
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      cycle(rst, cur_req, cur_pc, flush);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
